// File: rtl/tenkey_pkg.sv
// Shared definitions for the 10-key front-end conditioner.
//   KEY_W / CODE_W : key-line count and binary key-code width
//   state_t        : debounce FSM state encoding
//   is_onehot      : true when exactly one key line is set
//   onehot_to_code : index of the set bit of a one-hot key pattern
package tenkey_pkg;

   localparam int KEY_W  = 10;
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      logic [KEY_W-1:0] one;
      one = {{(KEY_W-1){1'b0}}, 1'b1};
      return (v != '0) && ((v & (v - one)) == '0);
   endfunction

   // OR of the indices of all set bits; exact only for one-hot input,
   // which is the only kind the FSM ever passes in.
   function automatic logic [CODE_W-1:0] onehot_to_code(input logic [KEY_W-1:0] v);
      logic [CODE_W-1:0] code;
      code = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (v[i]) code = code | CODE_W'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/tenkey_debounce_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//   ck    : clock
//   reset : synchronous active-high reset, clears both stages
//   d     : asynchronous input
//   q     : synchronised output (second stage)
module sync2 #(
   parameter int W = 10
) (
   input  logic         ck,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge ck) begin
      if (reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/tenkey_debounce.sv
// 10-key pad conditioner: synchronises the raw key lines, debounces press
// and release, and emits one single-cycle one-hot pulse per accepted key.
// Multi-key patterns are flagged with key_err instead of a pulse, and a
// full debounced release is needed before the next key is accepted.
//   ck         : clock
//   reset      : synchronous active-high reset
//   tenkey_raw : raw asynchronous key lines, 1 = pressed
//   key_pulse  : one-hot pulse, 1 cycle per accepted key
//   key_code   : binary code of the last accepted key (holds)
//   key_valid  : high with key_pulse
//   key_err    : 1-cycle pulse when a stable multi-key pattern is seen
//   key_held   : high until the accepted/rejected pattern is released
//
// state     | meaning
// IDLE      | all keys released, waiting for a nonzero pattern
// DEB_PRESS | counting stable cycles of candidate pattern cand
// PRESSED   | pattern resolved (pulse or error), waiting for release
// DEB_REL   | counting stable all-released cycles
module tenkey_debounce #(
   parameter int DB_CYCLES = 3,
   parameter int KEY_W     = 10
) (
   input  logic             ck,
   input  logic             reset,
   input  logic [KEY_W-1:0] tenkey_raw,
   output logic [KEY_W-1:0] key_pulse,
   output logic [3:0]       key_code,
   output logic             key_valid,
   output logic             key_err,
   output logic             key_held
);

   import tenkey_pkg::*;

   localparam logic [7:0] DB_MAX = 8'(DB_CYCLES);

   logic [KEY_W-1:0]  s2;
   state_t            state, state_nx;
   logic [7:0]        cnt, cnt_nx;
   logic [KEY_W-1:0]  cand, cand_nx;
   logic [KEY_W-1:0]  pulse_nx;
   logic [CODE_W-1:0] code_nx;
   logic              valid_nx, err_nx;

   sync2 #(.W(KEY_W)) u_sync (
      .ck    (ck),
      .reset (reset),
      .d     (tenkey_raw),
      .q     (s2)
   );

   always_ff @(posedge ck) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_pulse <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         key_pulse <= pulse_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
         key_err   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      pulse_nx = '0;
      code_nx  = key_code;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (s2 != '0) begin
               state_nx = DEB_PRESS;
               cand_nx  = s2;
               cnt_nx   = 8'd1;
            end
         end
         DEB_PRESS: begin
            if (s2 == '0) begin
               state_nx = IDLE;
            end else if (s2 != cand) begin
               // pattern changed (bounce or extra key): restart on new pattern
               cand_nx = s2;
               cnt_nx  = 8'd1;
            end else if (cnt == DB_MAX) begin
               state_nx = PRESSED;
               if (is_onehot(cand)) begin
                  pulse_nx = cand;
                  valid_nx = 1'b1;
                  code_nx  = onehot_to_code(cand);
               end else begin
                  err_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         PRESSED: begin
            if (s2 == '0) begin
               state_nx = DEB_REL;
               cnt_nx   = 8'd1;
            end
         end
         DEB_REL: begin
            if (s2 != '0) begin
               state_nx = PRESSED;
            end else if (cnt == DB_MAX) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign key_held = (state == PRESSED) || (state == DEB_REL);

endmodule

// File: tb/tb_tenkey_debounce.sv
module tb_tenkey_debounce;

   localparam int DB = 3;

   logic       ck = 1'b0;
   logic       reset;
   logic [9:0] tenkey_raw;
   logic [9:0] key_pulse;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_err;
   logic       key_held;

   int errors = 0;
   int checks = 0;

   always #5 ck = ~ck;

   tenkey_debounce #(.DB_CYCLES(DB)) dut (
      .ck         (ck),
      .reset      (reset),
      .tenkey_raw (tenkey_raw),
      .key_pulse  (key_pulse),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_err    (key_err),
      .key_held   (key_held)
   );

   // Reference model: a key is accepted once the synchronised pattern has
   // been the same nonzero value for DB+1 consecutive samples while unlocked;
   // acceptance locks, and DB+1 consecutive all-zero samples unlock.
   logic [9:0] m_s1, m_s2, m_prev;
   int         m_run;
   bit         m_locked;
   logic [9:0] e_pulse;
   logic [3:0] e_code;
   logic       e_valid, e_err;

   int         n_pulse = 0;
   int         n_err = 0;
   logic [3:0] q_codes[$];

   typedef struct {
      logic [9:0] raw;
      logic       rst;
      logic [9:0] pulse;
      logic [3:0] code;
      logic       valid;
      logic       err;
      logic       held;
   } tv_t;

   tv_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [9:0] r, input logic rs, input bit cmp);
      logic [9:0] x;
      tenkey_raw = r;
      reset      = rs;
      @(posedge ck);
      if (rs) begin
         m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0; m_locked = 0;
         e_pulse = '0; e_code = '0; e_valid = 0; e_err = 0;
      end else begin
         x    = m_s2;
         m_s2 = m_s1;
         m_s1 = r;
         if (x == m_prev) m_run++;
         else m_run = 1;
         m_prev  = x;
         e_pulse = '0; e_valid = 0; e_err = 0;
         if (!m_locked && x != 0 && m_run == DB + 1) begin
            m_locked = 1;
            if ($countones(x) == 1) begin
               e_pulse = x;
               e_valid = 1;
               for (int i = 0; i < 10; i++) if (x == (10'd1 << i)) e_code = 4'(i);
            end else begin
               e_err = 1;
            end
         end else if (m_locked && x == 0 && m_run == DB + 1) begin
            m_locked = 0;
         end
      end
      #1;
      if (key_valid === 1'b1) begin
         n_pulse++;
         q_codes.push_back(key_code);
      end
      if (key_err === 1'b1) n_err++;
      if (cmp) begin
         chk("key_pulse", 32'(key_pulse), 32'(e_pulse));
         chk("key_valid", 32'(key_valid), 32'(e_valid));
         chk("key_err",   32'(key_err),   32'(e_err));
         chk("key_code",  32'(key_code),  32'(e_code));
         chk("key_held",  32'(key_held),  32'(m_locked));
      end
   endtask

   task automatic hold(input logic [9:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, e0, lat, len, sel;
      logic [9:0] pat;

      // clean press of key 1, held exactly DB+1 cycles
      for (int i = 0; i < 12; i++)
         tbl[i] = '{raw: 10'd0, rst: 1'b0, pulse: 10'd0, code: 4'd0, valid: 1'b0, err: 1'b0, held: 1'b0};
      tbl[0].rst = 1'b1;
      for (int i = 1; i <= 4; i++) tbl[i].raw = 10'b0000000010;
      tbl[6].pulse = 10'b0000000010;
      tbl[6].valid = 1'b1;
      for (int i = 6; i < 12; i++) tbl[i].code = 4'd1;
      for (int i = 6; i <= 9; i++) tbl[i].held = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].raw, tbl[i].rst, 1'b0);
         chk($sformatf("tbl%0d_pulse", i), 32'(key_pulse), 32'(tbl[i].pulse));
         chk($sformatf("tbl%0d_valid", i), 32'(key_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl%0d_err",   i), 32'(key_err),   32'(tbl[i].err));
         chk($sformatf("tbl%0d_code",  i), 32'(key_code),  32'(tbl[i].code));
         chk($sformatf("tbl%0d_held",  i), 32'(key_held),  32'(tbl[i].held));
      end
      hold(10'd0, 6);

      // bounce on key 3, then stable
      p0 = n_pulse;
      hold(10'd8, 1); hold(10'd0, 1); hold(10'd8, 1); hold(10'd0, 1);
      chk("bounce_no_pulse", 32'(n_pulse), 32'(p0));
      lat = -1;
      for (int k = 0; k < 14; k++) begin
         step((k < 6) ? 10'd8 : 10'd0, 1'b0, 1'b1);
         if (key_valid === 1'b1 && lat < 0) lat = k;
      end
      chk("bounce_latency", 32'(lat), 32'(DB + 2));
      chk("bounce_count", 32'(n_pulse), 32'(p0 + 1));
      chk("bounce_code", 32'(key_code), 32'd3);

      // keys 1..4 with minimum gaps, then key 9 held long
      q_codes.delete();
      for (int k = 1; k <= 4; k++) begin
         hold(10'd1 << k, 4);
         hold(10'd0, 4);
      end
      hold(10'd0, 6);
      chk("seq_count", 32'(q_codes.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("seq_code%0d", k), (k < q_codes.size()) ? 32'(q_codes[k]) : 32'hdead, 32'(k + 1));
      p0 = n_pulse;
      hold(10'd1 << 9, 20);
      hold(10'd0, 8);
      chk("long_hold_count", 32'(n_pulse), 32'(p0 + 1));
      chk("long_hold_code", 32'(key_code), 32'd9);

      // multi-key 5+7 rejected, next clean 9 accepted
      p0 = n_pulse; e0 = n_err;
      hold(10'b0010100000, 6);
      hold(10'd0, 8);
      chk("multi_err", 32'(n_err), 32'(e0 + 1));
      chk("multi_no_pulse", 32'(n_pulse), 32'(p0));
      chk("multi_code_kept", 32'(key_code), 32'd9);
      q_codes.delete();
      hold(10'd1 << 9, 4);
      hold(10'd0, 8);
      chk("after_multi_count", 32'(q_codes.size()), 32'd1);
      chk("after_multi_code", (q_codes.size() > 0) ? 32'(q_codes[0]) : 32'hdead, 32'd9);

      // release glitch, then full release and re-press of 2
      q_codes.delete();
      hold(10'd4, 6); hold(10'd0, 1); hold(10'd4, 6);
      chk("glitch_one_pulse", 32'(q_codes.size()), 32'd1);
      hold(10'd0, DB + 1);
      hold(10'd4, 4);
      hold(10'd0, 8);
      chk("repress_count", 32'(q_codes.size()), 32'd2);

      // reset while debouncing key 6, key still held afterwards
      hold(10'd1 << 6, 3);
      step(10'd1 << 6, 1'b1, 1'b1);
      chk("rst_pulse", 32'(key_pulse), 32'd0);
      chk("rst_code", 32'(key_code), 32'd0);
      chk("rst_held", 32'(key_held), 32'd0);
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         step(10'd1 << 6, 1'b0, 1'b1);
         if (key_valid === 1'b1) lat = k;
      end
      chk("rst_repress_latency", 32'(lat), 32'(DB + 2));
      chk("rst_repress_code", 32'(key_code), 32'd6);
      hold(10'd0, 8);

      // randomized segments against the model
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 39) == 0) step(10'd0, 1'b1, 1'b1);
         sel = $urandom_range(0, 9);
         len = $urandom_range(1, 8);
         if (sel < 2) pat = '0;
         else if (sel < 8) pat = 10'd1 << $urandom_range(0, 9);
         else pat = 10'($urandom);
         if (sel == 9) begin
            for (int i = 0; i < len; i++) step((i % 2 == 0) ? (10'd1 << 2) : 10'd0, 1'b0, 1'b1);
         end else begin
            hold(pat, len);
         end
      end
      hold(10'd0, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
